// File: rtl/dcache_port_responder_pkg.sv
// Shared types and constants for the data-cache port responder.
// Covers the FSM state encoding, address field widths and the word-address helper.
package dcache_port_responder_pkg;

    localparam int INDEX_W     = 12;
    localparam int TAG_W       = 22;
    localparam int PLEN        = 34;
    localparam int WORD_ADDR_W = PLEN - 2;

    // A kill arriving together with the late tag always aborts the load.
    localparam bit KILL_OVER_TAG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        TAG,
        LAT,
        RESP
    } state_t;

    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [TAG_W-1:0]   tag,
                                                         input logic [INDEX_W-1:0] index);
        return WORD_ADDR_W'({tag, index} >> 2);
    endfunction

endpackage

// File: rtl/dcache_port_responder_if.sv
// Request/response bundle of the CVA6 data-cache port as seen by the responder.
// The master side is the LSU (or bench); the slave side is the responder.
interface dcache_port_responder_if;
    import dcache_port_responder_pkg::*;

    logic [INDEX_W-1:0] address_index_i;
    logic [TAG_W-1:0]   address_tag_i;
    logic [31:0]        data_wdata_i;
    logic               data_req_i;
    logic               data_we_i;
    logic [3:0]         data_be_i;
    logic [1:0]         data_size_i;
    logic               kill_req_i;
    logic               tag_valid_i;
    logic               stall_i;
    logic               data_gnt_o;
    logic               data_rvalid_o;
    logic [31:0]        data_rdata_o;
    logic [15:0]        store_count_o;
    logic               err_o;

    modport master (
        output address_index_i, address_tag_i, data_wdata_i, data_req_i, data_we_i,
               data_be_i, data_size_i, kill_req_i, tag_valid_i, stall_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, store_count_o, err_o
    );

    modport slave (
        input  address_index_i, address_tag_i, data_wdata_i, data_req_i, data_we_i,
               data_be_i, data_size_i, kill_req_i, tag_valid_i, stall_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, store_count_o, err_o
    );

endinterface

// File: rtl/dcache_resp_mem.sv
// Backing word array: synchronous byte-enabled write, combinational read.
// Contents are deliberately left untouched by reset.
module dcache_resp_mem #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dcache_port_responder.sv
// Memory-side responder for the CVA6 data-cache request port (grant delay, late-tag loads).
// Define DCACHE_PORT_RESPONDER_STORE_ACK_EN to make every granted store return a zero rvalid beat.
module dcache_port_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int GNT_DELAY    = 0,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dcache_port_responder_if.slave  bus
);
    import dcache_port_responder_pkg::*;

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int WCW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
    localparam int LCW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(GNT_DELAY);
    localparam logic [LCW-1:0] LAT_LOAD = LCW'(LOAD_LATENCY - 1);

    state_t                 state;
    logic [WCW-1:0]         wcnt;
    logic [LCW-1:0]         lat_cnt;
    logic [INDEX_W-1:0]     index_p0;
    logic [31:0]            word_p1;
    logic                   vld_p2;
    logic [31:0]            rdata_p2;
    logic [15:0]            store_count;
    logic                   err;

    logic                   gnt;
    logic                   store_gnt;
    logic                   load_gnt;
    logic [WORD_ADDR_W-1:0] req_waddr;
    logic [WORD_ADDR_W-1:0] tag_waddr;
    logic                   req_in_range;
    logic                   tag_in_range;
    logic [31:0]            mem_rdata;
    logic [31:0]            tag_word;
    logic                   unused_size;

    function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
        return (v == WAIT_MAX) ? v : v + 1'b1;
    endfunction

    // data_size is informational; byte enables alone decide what is written
    assign unused_size = ^bus.data_size_i;

    assign gnt       = (state == IDLE) && bus.data_req_i && !bus.stall_i && (wcnt == WAIT_MAX);
    assign store_gnt = gnt && bus.data_we_i;
    assign load_gnt  = gnt && !bus.data_we_i;

    assign req_waddr    = word_addr(bus.address_tag_i, bus.address_index_i);
    assign tag_waddr    = word_addr(bus.address_tag_i, index_p0);
    assign req_in_range = req_waddr < WORD_ADDR_W'(MEM_WORDS);
    assign tag_in_range = tag_waddr < WORD_ADDR_W'(MEM_WORDS);
    assign tag_word     = tag_in_range ? mem_rdata : 32'h0;

    dcache_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (AW)
    ) u_mem (
        .clk     (clk_i),
        .wr_en   (store_gnt && req_in_range),
        .wr_addr (req_waddr[AW-1:0]),
        .wr_be   (bus.data_be_i),
        .wr_data (bus.data_wdata_i),
        .rd_addr (tag_waddr[AW-1:0]),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wcnt        <= '0;
            lat_cnt     <= '0;
            index_p0    <= '0;
            word_p1     <= '0;
            vld_p2      <= 1'b0;
            rdata_p2    <= '0;
            store_count <= '0;
            err         <= 1'b0;
        end else begin
            vld_p2   <= 1'b0;
            rdata_p2 <= '0;
            case (state)
                // request stage: wait counter, grant, store write
                IDLE: begin
                    if (gnt || !bus.data_req_i) wcnt <= '0;
                    else if (!bus.stall_i)      wcnt <= sat_inc(wcnt);
                    if (store_gnt) begin
                        store_count <= store_count + 16'd1;
                        if (!req_in_range) err <= 1'b1;
`ifdef DCACHE_PORT_RESPONDER_STORE_ACK_EN
                        state  <= RESP;
                        vld_p2 <= 1'b1;
`endif
                    end else if (load_gnt) begin
                        index_p0 <= bus.address_index_i;
                        state    <= TAG;
                    end
                end
                // tag stage: array read once the late tag shows up
                TAG: begin
                    if (bus.kill_req_i) begin
                        state <= IDLE;
                    end else if (bus.tag_valid_i) begin
                        word_p1 <= tag_word;
                        lat_cnt <= LAT_LOAD;
                        if (!tag_in_range) err <= 1'b1;
                        if (LOAD_LATENCY == 1) begin
                            state    <= RESP;
                            vld_p2   <= 1'b1;
                            rdata_p2 <= tag_word;
                        end else begin
                            state <= LAT;
                        end
                    end
                end
                // latency stage
                LAT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LCW'(1)) begin
                        state    <= RESP;
                        vld_p2   <= 1'b1;
                        rdata_p2 <= word_p1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = vld_p2;
    assign bus.data_rdata_o  = rdata_p2;
    assign bus.store_count_o = store_count;
    assign bus.err_o         = err;

endmodule

// File: tb/tb_dcache_port_responder.sv
// Directed bench for dcache_port_responder: two instances (no delay / latency 1, and
// grant delay 3 / latency 3) driven through linear steps with hand-computed expectations.
module tb_dcache_port_responder;
    import dcache_port_responder_pkg::*;

`ifdef DCACHE_PORT_RESPONDER_STORE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   tests = 0;
    int   fails = 0;

    dcache_port_responder_if bus0();
    dcache_port_responder_if bus1();

    dcache_port_responder #(.MEM_WORDS(1024), .GNT_DELAY(0), .LOAD_LATENCY(1)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0)
    );

    dcache_port_responder #(.MEM_WORDS(64), .GNT_DELAY(3), .LOAD_LATENCY(3)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic store0(input logic [11:0] idx, input logic [21:0] tg,
                          input logic [31:0] wd, input logic [3:0] bemask);
        @(negedge clk);
        bus0.data_req_i      = 1'b1;
        bus0.data_we_i       = 1'b1;
        bus0.address_index_i = idx;
        bus0.address_tag_i   = tg;
        bus0.data_wdata_i    = wd;
        bus0.data_be_i       = bemask;
        #1 chk("store_gnt", bus0.data_gnt_o, 1);
        @(posedge clk); #1;
        chk("store_ack_vld", bus0.data_rvalid_o, ACK);
        chk("store_ack_data", bus0.data_rdata_o, 0);
        @(negedge clk);
        bus0.data_req_i = 1'b0;
        bus0.data_we_i  = 1'b0;
        @(posedge clk); #1 chk("store_post_vld", bus0.data_rvalid_o, 0);
    endtask

    task automatic load0(input string name, input logic [11:0] idx, input logic [21:0] tg,
                         input logic [31:0] exp);
        @(negedge clk);
        bus0.data_req_i      = 1'b1;
        bus0.data_we_i       = 1'b0;
        bus0.address_index_i = idx;
        bus0.address_tag_i   = ~tg;
        #1 chk({name, "_gnt"}, bus0.data_gnt_o, 1);
        @(negedge clk);
        bus0.data_req_i      = 1'b0;
        bus0.tag_valid_i     = 1'b1;
        bus0.address_tag_i   = tg;
        bus0.address_index_i = ~idx;
        @(posedge clk); #1;
        chk({name, "_vld"}, bus0.data_rvalid_o, 1);
        chk({name, "_data"}, bus0.data_rdata_o, exp);
        @(negedge clk);
        bus0.tag_valid_i = 1'b0;
        @(posedge clk); #1 chk({name, "_post_vld"}, bus0.data_rvalid_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        {bus0.data_req_i, bus0.data_we_i, bus0.kill_req_i, bus0.tag_valid_i, bus0.stall_i} = '0;
        {bus1.data_req_i, bus1.data_we_i, bus1.kill_req_i, bus1.tag_valid_i, bus1.stall_i} = '0;
        bus0.address_index_i = '0; bus0.address_tag_i = '0; bus0.data_wdata_i = '0;
        bus0.data_be_i = '0; bus0.data_size_i = 2'd2;
        bus1.address_index_i = '0; bus1.address_tag_i = '0; bus1.data_wdata_i = '0;
        bus1.data_be_i = '0; bus1.data_size_i = 2'd2;

        // reset values
        @(posedge clk); #1;
        chk("rst_gnt", bus0.data_gnt_o, 0);
        chk("rst_vld", bus0.data_rvalid_o, 0);
        chk("rst_rdata", bus0.data_rdata_o, 0);
        chk("rst_count", bus0.store_count_o, 0);
        chk("rst_err", bus0.err_o, 0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // full store then load back
        store0(12'h010, 22'h0, 32'h1234_5678, 4'b1111);
        chk("count_1", bus0.store_count_o, 1);
        load0("ld_full", 12'h010, 22'h0, 32'h1234_5678);

        // partial store over a cleared word
        store0(12'h000, 22'h0, 32'h0, 4'b1111);
        store0(12'h000, 22'h0, 32'hAABB_CCDD, 4'b0010);
        load0("ld_part", 12'h000, 22'h0, 32'h0000_CC00);
        chk("err_clean", bus0.err_o, 0);

        // kill together with tag: no response, regrant from IDLE
        @(negedge clk);
        bus0.data_req_i = 1'b1; bus0.data_we_i = 1'b0;
        bus0.address_index_i = 12'h010; bus0.address_tag_i = 22'h0;
        #1 chk("kill_ld_gnt", bus0.data_gnt_o, 1);
        @(negedge clk);
        bus0.kill_req_i = 1'b1; bus0.tag_valid_i = 1'b1;
        #1 chk("tag_no_gnt", bus0.data_gnt_o, 0);
        @(posedge clk); #1 chk("kill_vld", bus0.data_rvalid_o, !KILL_OVER_TAG);
        @(negedge clk);
        bus0.kill_req_i = 1'b0; bus0.tag_valid_i = 1'b0;
        #1 chk("kill_regnt", bus0.data_gnt_o, 1);
        @(negedge clk);
        bus0.data_req_i = 1'b0; bus0.tag_valid_i = 1'b1;
        @(posedge clk); #1;
        chk("regnt_vld", bus0.data_rvalid_o, 1);
        chk("regnt_data", bus0.data_rdata_o, 32'h1234_5678);
        @(negedge clk);
        bus0.tag_valid_i = 1'b0;

        // out-of-range store aliasing word 0 must not write
        store0(12'h000, 22'h30_0000, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_err", bus0.err_o, 1);
        chk("oor_count", bus0.store_count_o, 4);
        load0("ld_after_oor", 12'h000, 22'h0, 32'h0000_CC00);
        load0("ld_oor", 12'h000, 22'h30_0000, 32'h0);
        chk("err_sticky", bus0.err_o, 1);

        // grant delay 3 with a stall pulse in the second wait cycle
        @(negedge clk);
        bus1.data_req_i = 1'b1; bus1.data_we_i = 1'b1;
        bus1.address_index_i = 12'h004; bus1.address_tag_i = 22'h0;
        bus1.data_wdata_i = 32'hCAFE_F00D; bus1.data_be_i = 4'b1111;
        #1 chk("d3_c0", bus1.data_gnt_o, 0);
        @(negedge clk); bus1.stall_i = 1'b1;
        #1 chk("d3_c1_stall", bus1.data_gnt_o, 0);
        @(negedge clk); bus1.stall_i = 1'b0;
        #1 chk("d3_c2", bus1.data_gnt_o, 0);
        @(negedge clk);
        #1 chk("d3_c3", bus1.data_gnt_o, 0);
        @(negedge clk);
        #1 chk("d3_c4_gnt", bus1.data_gnt_o, 1);
        @(posedge clk); #1 chk("d3_count", bus1.store_count_o, 1);
        @(negedge clk);
        bus1.data_req_i = 1'b0; bus1.data_we_i = 1'b0;

        // load latency 3 on the delayed instance
        @(negedge clk);
        bus1.data_req_i = 1'b1; bus1.address_index_i = 12'h004;
        for (int k = 0; k < 3; k++) begin
            #1 chk("ld3_wait", bus1.data_gnt_o, 0);
            @(negedge clk);
        end
        #1 chk("ld3_gnt", bus1.data_gnt_o, 1);
        @(negedge clk);
        bus1.data_req_i = 1'b0; bus1.tag_valid_i = 1'b1;
        @(posedge clk); #1 chk("ld3_u1", bus1.data_rvalid_o, 0);
        @(negedge clk); bus1.tag_valid_i = 1'b0;
        @(posedge clk); #1 chk("ld3_u2", bus1.data_rvalid_o, 0);
        @(posedge clk); #1;
        chk("ld3_u3_vld", bus1.data_rvalid_o, 1);
        chk("ld3_u3_data", bus1.data_rdata_o, 32'hCAFE_F00D);
        @(posedge clk); #1 chk("ld3_done", bus1.data_rvalid_o, 0);

        // reset while in LAT loses the response
        @(negedge clk);
        bus1.data_req_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("rl_gnt", bus1.data_gnt_o, 1);
        @(negedge clk);
        bus1.data_req_i = 1'b0; bus1.tag_valid_i = 1'b1;
        @(negedge clk);
        bus1.tag_valid_i = 1'b0;
        #1 rst1 = 1'b1;
        #1;
        chk("rl_vld", bus1.data_rvalid_o, 0);
        chk("rl_rdata", bus1.data_rdata_o, 0);
        chk("rl_count", bus1.store_count_o, 0);
        chk("rl_gnt_low", bus1.data_gnt_o, 0);
        @(negedge clk); rst1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1 chk("rl_lost", bus1.data_rvalid_o, 0);
        end

        // store counter wrap
        @(negedge clk); rst0 = 1'b1;
        #1;
        chk("rst2_count", bus0.store_count_o, 0);
        chk("rst2_err", bus0.err_o, 0);
        @(negedge clk);
        rst0 = 1'b0;
        bus0.data_req_i = 1'b1; bus0.data_we_i = 1'b1;
        bus0.address_index_i = 12'h020; bus0.address_tag_i = 22'h0;
        bus0.data_wdata_i = 32'h5A5A_5A5A; bus0.data_be_i = 4'b1111;
`ifdef DCACHE_PORT_RESPONDER_STORE_ACK_EN
        repeat (4) @(posedge clk);
        #1 chk("ack_pace_count", bus0.store_count_o, 2);
`else
        repeat (65535) @(posedge clk);
        #1 chk("wrap_ffff", bus0.store_count_o, 16'hFFFF);
        @(posedge clk); #1 chk("wrap_zero", bus0.store_count_o, 0);
`endif
        @(negedge clk);
        bus0.data_req_i = 1'b0; bus0.data_we_i = 1'b0;
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
